// File: rtl/cci_csr_rd_sched_pkg.sv
// Shared types for the CCI MMIO/CSR scheduler: CCI c0 Rx subset, read queue entry and FSM states.
package cci_csr_sched_pkg;

    typedef logic [8:0]  t_cci_tid;
    typedef logic [15:0] t_cci_mmioAddr;

    typedef struct packed {
        t_cci_mmioAddr address;
        logic [1:0]    length;
        logic          rsvd;
        t_cci_tid      tid;
    } t_cci_c0_ReqMmioHdr;

    typedef struct packed {
        t_cci_c0_ReqMmioHdr hdr;
        logic [511:0]       data;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_cci_c0_Rx;

    typedef struct packed {
        t_cci_tid      tid;
        t_cci_mmioAddr addr;
        logic [3:0]    sel;
        logic          oor;
    } t_csr_rd_entry;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } t_csr_sched_state;

    localparam logic [63:0] CSR_RD_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/cci_csr_rd_sched_if.sv
// Bundle of host-side MMIO and client-side CSR signals around the read scheduler.
interface cci_csr_rd_sched_if
    import cci_csr_sched_pkg::*;
#(
    parameter int N_CLIENTS = 4
);
    t_if_cci_c0_Rx           c0Rx;
    logic                    c2Tx_mmioRdValid;
    t_cci_tid                c2Tx_tid;
    logic [63:0]             c2Tx_data;
    logic [N_CLIENTS-1:0]    csr_wr_valid;
    t_cci_mmioAddr           csr_wr_addr;
    logic [63:0]             csr_wr_data;
    logic [N_CLIENTS-1:0]    csr_rd_req;
    t_cci_mmioAddr           csr_rd_addr;
    logic [N_CLIENTS-1:0]    csr_rd_rsp_valid;
    logic [N_CLIENTS*64-1:0] csr_rd_rsp_data;
    logic                    err_overflow;
    logic [15:0]             timeout_cnt;

    modport master (
        input  c0Rx, csr_rd_rsp_valid, csr_rd_rsp_data,
        output c2Tx_mmioRdValid, c2Tx_tid, c2Tx_data,
        output csr_wr_valid, csr_wr_addr, csr_wr_data,
        output csr_rd_req, csr_rd_addr, err_overflow, timeout_cnt
    );

    modport slave (
        output c0Rx, csr_rd_rsp_valid, csr_rd_rsp_data,
        input  c2Tx_mmioRdValid, c2Tx_tid, c2Tx_data,
        input  csr_wr_valid, csr_wr_addr, csr_wr_data,
        input  csr_rd_req, csr_rd_addr, err_overflow, timeout_cnt
    );

endinterface

// File: rtl/cci_csr_rd_req_fifo.sv
// Registered FIFO of pending MMIO reads; push and pop may coincide even when full or empty.
module cci_csr_rd_req_fifo
    import cci_csr_sched_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  t_csr_rd_entry push_data,
    input  logic          pop,
    output t_csr_rd_entry pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    t_csr_rd_entry    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        cnt_d    = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/cci_csr_rd_sched.sv
// Decodes host MMIO writes into client strobes and serialises MMIO reads to CSR clients,
// returning each reply (or an all-ones fill on timeout) on the c2 Tx response channel.
module cci_csr_rd_sched
    import cci_csr_sched_pkg::*;
#(
    parameter int N_CLIENTS      = 4,
    parameter int SEL_LSB        = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 512
)(
    input logic                clk,
    input logic                reset,
    cci_csr_rd_sched_if.master bus
);

    localparam int SEL_W   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]         N_CL       = 5'(N_CLIENTS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [3:0] dec_sel(input t_cci_mmioAddr a);
        logic [3:0] s;
        s = '0;
        if (N_CLIENTS > 1) s[SEL_W-1:0] = a[SEL_LSB +: SEL_W];
        return s;
    endfunction

    function automatic logic [N_CLIENTS-1:0] sel_onehot(input logic [3:0] s);
        logic [N_CLIENTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_CLIENTS; i++) oh[i] = (s == 4'(i));
        return oh;
    endfunction

    t_if_cci_c0_Rx c0;
    t_cci_mmioAddr rx_addr;
    logic [3:0]    rx_sel;
    logic          rx_oor;
    logic          unused_rx;

    assign c0        = bus.c0Rx;
    assign rx_addr   = c0.hdr.address;
    assign rx_sel    = dec_sel(rx_addr);
    assign rx_oor    = ({1'b0, rx_sel} >= N_CL);
    assign unused_rx = ^{c0.data[511:64], c0.hdr.length, c0.hdr.rsvd};

    // Write path: one registered stage, independent of the read machinery.
    logic [N_CLIENTS-1:0] wr_valid_q, wr_valid_d;
    t_cci_mmioAddr        wr_addr_q, wr_addr_d;
    logic [63:0]          wr_data_q, wr_data_d;

    always_comb begin
        wr_valid_d = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (c0.mmioWrValid && !rx_oor) begin
            wr_valid_d = sel_onehot(rx_sel);
            wr_addr_d  = rx_addr;
            wr_data_d  = c0.data[63:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    t_csr_rd_entry push_entry, head;
    logic          err_q, err_d;

    assign fifo_push  = c0.mmioRdValid && !fifo_full;
    assign push_entry = '{tid: c0.hdr.tid, addr: rx_addr, sel: rx_sel, oor: rx_oor};
    assign err_d      = err_q || (c0.mmioRdValid && fifo_full);

    cci_csr_rd_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    t_csr_sched_state     state_q, state_d;
    t_cci_tid             tid_q, tid_d;
    logic [3:0]           sel_q, sel_d;
    logic [N_CLIENTS-1:0] rd_req_q, rd_req_d;
    t_cci_mmioAddr        rd_addr_q, rd_addr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 c2_vld_q, c2_vld_d;
    t_cci_tid             c2_tid_q, c2_tid_d;
    logic [63:0]          c2_data_q, c2_data_d;
    logic [15:0]          tcnt_q, tcnt_d;
    logic                 rsp_hit;
    logic [63:0]          rsp_data_sel;

    // Only the client that owns the in-flight read may complete it.
    always_comb begin
        rsp_hit      = |(bus.csr_rd_rsp_valid & sel_onehot(sel_q));
        rsp_data_sel = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (sel_q == 4'(i)) rsp_data_sel = bus.csr_rd_rsp_data[64*i +: 64];
        end
    end

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        tid_d     = tid_q;
        sel_d     = sel_q;
        rd_req_d  = '0;
        rd_addr_d = rd_addr_q;
        timer_d   = timer_q;
        c2_vld_d  = 1'b0;
        c2_tid_d  = c2_tid_q;
        c2_data_d = c2_data_q;
        tcnt_d    = tcnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tid_d    = head.tid;
                    sel_d    = head.sel;
                    if (head.oor) begin
                        c2_vld_d  = 1'b1;
                        c2_tid_d  = head.tid;
                        c2_data_d = CSR_RD_FILL;
                        state_d   = RESP;
                    end else begin
                        rd_req_d  = sel_onehot(head.sel);
                        rd_addr_d = head.addr;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (rsp_hit) begin
                    c2_vld_d  = 1'b1;
                    c2_tid_d  = tid_q;
                    c2_data_d = rsp_data_sel;
                    state_d   = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    c2_vld_d  = 1'b1;
                    c2_tid_d  = tid_q;
                    c2_data_d = CSR_RD_FILL;
                    if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                    state_d   = RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RESP: begin
                timer_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tid_q     <= '0;
            sel_q     <= '0;
            rd_req_q  <= '0;
            rd_addr_q <= '0;
            timer_q   <= '0;
            c2_vld_q  <= 1'b0;
            c2_tid_q  <= '0;
            c2_data_q <= '0;
            tcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tid_q     <= tid_d;
            sel_q     <= sel_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            timer_q   <= timer_d;
            c2_vld_q  <= c2_vld_d;
            c2_tid_q  <= c2_tid_d;
            c2_data_q <= c2_data_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.c2Tx_mmioRdValid = c2_vld_q;
    assign bus.c2Tx_tid         = c2_tid_q;
    assign bus.c2Tx_data        = c2_data_q;
    assign bus.csr_wr_valid     = wr_valid_q;
    assign bus.csr_wr_addr      = wr_addr_q;
    assign bus.csr_wr_data      = wr_data_q;
    assign bus.csr_rd_req       = rd_req_q;
    assign bus.csr_rd_addr      = rd_addr_q;
    assign bus.err_overflow     = err_q;
    assign bus.timeout_cnt      = tcnt_q;

endmodule
